cam_update_ctrl: RTL and testbench

// Write-side controller for an array of LUTRAM CAM match blocks. Each block holds

---
 rtl/cam_update_ctrl_if.sv | 50 +++++
 rtl/cam_update_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_cam_update_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_update_ctrl_if.sv
// -----------------------------------------------------------------------------
// cam_update_ctrl_if
// Bundles the signals between cam_update_ctrl and the logic around it:
//   - the update request handshake (upd_valid/upd_ready/upd_op/upd_entry/upd_key)
//   - the completion report (upd_done/upd_err)
//   - the LUTRAM write sweep bus (wr_en/wr_addr/wr_data) and search_stall
// Modports:
//   master : requester side; drives the request, observes everything else
//   slave  : the controller itself
// Optional macro CAM_UPD_TERNARY_EN adds upd_mask (1 = don't-care key bit).
// ENTRY_W defaults to $clog2(ENTRIES); it may be widened so that out-of-range
// entry indices are representable on the request side.
// -----------------------------------------------------------------------------
interface cam_update_ctrl_if #(
    parameter int ENTRIES = 32,
    parameter int SLICES  = 4,
    parameter int SLICE_W = 6,
    parameter int ENTRY_W = $clog2(ENTRIES)
);
    logic                       upd_valid;
    logic                       upd_ready;
    logic                       upd_op;
    logic [ENTRY_W-1:0]         upd_entry;
    logic [SLICES*SLICE_W-1:0]  upd_key;
`ifdef CAM_UPD_TERNARY_EN
    logic [SLICES*SLICE_W-1:0]  upd_mask;
`endif
    logic [ENTRIES-1:0]         wr_en;
    logic [SLICE_W-1:0]         wr_addr;
    logic [SLICES-1:0]          wr_data;
    logic                       search_stall;
    logic                       upd_done;
    logic                       upd_err;

    modport master (
`ifdef CAM_UPD_TERNARY_EN
        output upd_mask,
`endif
        output upd_valid, upd_op, upd_entry, upd_key,
        input  upd_ready, wr_en, wr_addr, wr_data, search_stall, upd_done, upd_err
    );

    modport slave (
`ifdef CAM_UPD_TERNARY_EN
        input  upd_mask,
`endif
        input  upd_valid, upd_op, upd_entry, upd_key,
        output upd_ready, wr_en, wr_addr, wr_data, search_stall, upd_done, upd_err
    );
endinterface

// File: rtl/cam_update_ctrl.sv
// -----------------------------------------------------------------------------
// cam_update_ctrl
// Write-side controller for an array of LUTRAM CAM match blocks. Each accepted
// write/delete becomes a SLICE_DEPTH-cycle sweep of the shared LUTRAM write
// address; during the sweep each LUTRAM of the target block gets a 1 only at
// the address equal to its key slice (all zeros for a delete). The search path
// is stalled while any write enable may be high.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : cam_update_ctrl_if.slave
//            request  : upd_valid, upd_ready, upd_op (1=write, 0=delete),
//                       upd_entry, upd_key (slice s = upd_key[s*SLICE_W +: SLICE_W])
//            report   : upd_done (1-cycle pulse), upd_err (entry out of range)
//            LUTRAM   : wr_en (one-hot per block), wr_addr, wr_data (bit per slice),
//                       search_stall
// Optional macro CAM_UPD_TERNARY_EN: latch upd_mask with the key; masked key
// bits are don't-care, so a slice writes 1 at every address matching the
// unmasked bits (a fully masked slice writes all ones).
// A reset in mid-sweep leaves that entry partially written; software must
// rewrite it.
// -----------------------------------------------------------------------------
module cam_update_ctrl #(
    parameter int ENTRIES = 32,
    parameter int SLICES  = 4,
    parameter int SLICE_W = 6,
    parameter int ENTRY_W = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst_n,
    cam_update_ctrl_if.slave  bus
);

    localparam int KEY_W = SLICES * SLICE_W;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    state_t               state_q;
    logic                 op_q;
    logic [ENTRY_W-1:0]   entry_q;
    logic [KEY_W-1:0]     key_q;
    logic [KEY_W-1:0]     mask_q;
    logic [SLICE_W-1:0]   cnt_q;
    logic [ENTRIES-1:0]   wrEn_q;
    logic [SLICES-1:0]    wrData_q;
    logic                 stall_q;
    logic                 ready_q;
    logic                 done_q;
    logic                 err_q;

    logic                 accept;
    logic                 entryBad;
    logic                 opSel;
    logic [ENTRY_W-1:0]   entrySel;
    logic [KEY_W-1:0]     keySel;
    logic [KEY_W-1:0]     maskSel;
    logic [KEY_W-1:0]     reqMask;
    logic [SLICE_W-1:0]   cnt_d;
    logic [ENTRIES-1:0]   wrEn_d;
    logic [SLICES-1:0]    wrData_d;
    logic [SLICE_W-1:0]   keySlice;
    logic [SLICE_W-1:0]   maskSlice;

`ifdef CAM_UPD_TERNARY_EN
    assign reqMask = bus.upd_mask;
`else
    assign reqMask = '0;
`endif

    // Next-beat values. In IDLE the first beat is built straight from the
    // request inputs so that wr_en rises on the cycle after acceptance; in
    // SWEEP the latched copy is used, which makes input changes while busy
    // harmless. cnt wraps to 0 after the last address by plain overflow.
    always_comb begin
        accept    = 1'b0;
        entryBad  = 1'b0;
        opSel     = op_q;
        entrySel  = entry_q;
        keySel    = key_q;
        maskSel   = mask_q;
        cnt_d     = '0;
        wrEn_d    = '0;
        wrData_d  = '0;
        keySlice  = '0;
        maskSlice = '0;

        accept   = (state_q == IDLE) && ready_q && bus.upd_valid;
        entryBad = ({1'b0, bus.upd_entry} >= (ENTRY_W+1)'(ENTRIES));

        if (state_q == IDLE) begin
            opSel    = bus.upd_op;
            entrySel = bus.upd_entry;
            keySel   = bus.upd_key;
            maskSel  = reqMask;
            cnt_d    = '0;
        end else begin
            cnt_d    = cnt_q + SLICE_W'(1);
        end

        wrEn_d = {{(ENTRIES-1){1'b0}}, 1'b1} << entrySel;

        for (int s = 0; s < SLICES; s++) begin
            keySlice    = keySel[s*SLICE_W +: SLICE_W];
            maskSlice   = maskSel[s*SLICE_W +: SLICE_W];
            wrData_d[s] = opSel & ((cnt_d & ~maskSlice) == (keySlice & ~maskSlice));
        end
    end

    // Controller FSM with registered outputs: IDLE -> SWEEP -> DONE -> IDLE.
    // An out-of-range entry skips SWEEP entirely so no write enable is raised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= 1'b0;
            entry_q  <= '0;
            key_q    <= '0;
            mask_q   <= '0;
            cnt_q    <= '0;
            wrEn_q   <= '0;
            wrData_q <= '0;
            stall_q  <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q    <= bus.upd_op;
                        entry_q <= bus.upd_entry;
                        key_q   <= bus.upd_key;
                        mask_q  <= reqMask;
                        ready_q <= 1'b0;
                        if (entryBad) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q  <= SWEEP;
                            cnt_q    <= cnt_d;
                            wrEn_q   <= wrEn_d;
                            wrData_q <= wrData_d;
                            stall_q  <= 1'b1;
                        end
                    end
                end
                SWEEP: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == '1) begin
                        state_q  <= DONE;
                        wrEn_q   <= '0;
                        wrData_q <= '0;
                        stall_q  <= 1'b0;
                        done_q   <= 1'b1;
                        err_q    <= 1'b0;
                    end else begin
                        wrData_q <= wrData_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q  <= IDLE;
                    cnt_q    <= '0;
                    wrEn_q   <= '0;
                    wrData_q <= '0;
                    stall_q  <= 1'b0;
                    done_q   <= 1'b0;
                    err_q    <= 1'b0;
                    ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.upd_ready    = ready_q;
    assign bus.wr_en        = wrEn_q;
    assign bus.wr_addr      = cnt_q;
    assign bus.wr_data      = wrData_q;
    assign bus.search_stall = stall_q;
    assign bus.upd_done     = done_q;
    assign bus.upd_err      = err_q;

endmodule

// File: tb/tb_cam_update_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cam_update_ctrl
// Directed bench for cam_update_ctrl. Each accepted request pushes its full
// expected output sequence (sweep beats, done beat, ready beat) into a queue;
// every cycle after the active edge one entry is popped and compared with the
// observed outputs. The interface is built with ENTRY_W=6 so that entry
// indices beyond ENTRIES can be requested.
// -----------------------------------------------------------------------------
module tb_cam_update_ctrl;

    localparam int ENTRIES = 32;
    localparam int SLICES  = 4;
    localparam int SLICE_W = 6;
    localparam int ENTRY_W = 6;
    localparam int DEPTH   = 64;
    localparam int KEY_W   = SLICES * SLICE_W;

    typedef struct packed {
        logic [ENTRIES-1:0] en;
        logic [SLICE_W-1:0] addr;
        logic [SLICES-1:0]  data;
        logic               stall;
        logic               ready;
        logic               done;
        logic               err;
    } beat_t;

    typedef struct {
        beat_t v;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [KEY_W-1:0] reqMask = '0;

    exp_t        expQ[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [DEPTH-1:0] hitMap[SLICES];

    always #5 clk = ~clk;

    cam_update_ctrl_if #(
        .ENTRIES(ENTRIES), .SLICES(SLICES), .SLICE_W(SLICE_W), .ENTRY_W(ENTRY_W)
    ) camBus ();

`ifdef CAM_UPD_TERNARY_EN
    assign camBus.upd_mask = reqMask;
`endif

    cam_update_ctrl #(
        .ENTRIES(ENTRIES), .SLICES(SLICES), .SLICE_W(SLICE_W), .ENTRY_W(ENTRY_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (camBus)
    );

    // Watchdog so a stuck design still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic beat_t mkBeat(logic [ENTRIES-1:0] en, logic [SLICE_W-1:0] addr,
                                     logic [SLICES-1:0] data, logic stall, logic ready,
                                     logic done, logic err);
        beat_t b;
        b.en = en; b.addr = addr; b.data = data; b.stall = stall;
        b.ready = ready; b.done = done; b.err = err;
        return b;
    endfunction

    function automatic beat_t observe();
        return mkBeat(camBus.wr_en, camBus.wr_addr, camBus.wr_data,
                      camBus.search_stall, camBus.upd_ready, camBus.upd_done, camBus.upd_err);
    endfunction

    // Reference: a slice bit is 1 when the address equals the key slice on
    // every bit not marked don't-care.
    function automatic logic [SLICES-1:0] modelData(logic op, logic [KEY_W-1:0] key,
                                                    logic [KEY_W-1:0] mask, int addr);
        logic [SLICES-1:0] d;
        logic [SLICE_W-1:0] a, k, m;
        a = SLICE_W'(addr);
        for (int s = 0; s < SLICES; s++) begin
            k = key[s*SLICE_W +: SLICE_W];
`ifdef CAM_UPD_TERNARY_EN
            m = mask[s*SLICE_W +: SLICE_W];
`else
            m = '0;
`endif
            d[s] = op && ((a & ~m) == (k & ~m));
        end
        return d;
    endfunction

    task automatic pushRequest(logic op, logic [ENTRY_W-1:0] entry, logic [KEY_W-1:0] key,
                               logic [KEY_W-1:0] mask, string tag);
        exp_t e;
        if (entry >= ENTRIES) begin
            e.v = mkBeat('0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1); e.tag = {tag, "_err"};
            expQ.push_back(e);
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                e.v = mkBeat(ENTRIES'(1) << entry, SLICE_W'(a), modelData(op, key, mask, a),
                             1'b1, 1'b0, 1'b0, 1'b0);
                e.tag = $sformatf("%s_addr%0d", tag, a);
                expQ.push_back(e);
            end
            e.v = mkBeat('0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0); e.tag = {tag, "_done"};
            expQ.push_back(e);
        end
        e.v = mkBeat('0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0); e.tag = {tag, "_ready"};
        expQ.push_back(e);
    endtask

    task automatic checkValue(string tag, logic [127:0] observed, logic [127:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic compareBeat();
        exp_t  e;
        beat_t obs;
        obs = observe();
        if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL queue_underflow: observed %0h expected a queued beat", obs);
        end else begin
            e = expQ.pop_front();
            vectors++;
            assert (obs === e.v) else begin
                miscompares++;
                $error("[TB] FAIL %s: observed %0h expected %0h", e.tag, obs, e.v);
            end
        end
        for (int s = 0; s < SLICES; s++)
            if (obs.data[s] === 1'b1) hitMap[s][obs.addr] = 1'b1;
    endtask

    task automatic checkOutput(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            compareBeat();
        end
    endtask

    task automatic applyStimulus(logic op, logic [ENTRY_W-1:0] entry, logic [KEY_W-1:0] key,
                                 logic [KEY_W-1:0] mask);
        camBus.upd_op    = op;
        camBus.upd_entry = entry;
        camBus.upd_key   = key;
        reqMask          = mask;
        camBus.upd_valid = 1'b1;
    endtask

    // Waits (bounded) for upd_ready while upd_valid is high; the next edge
    // accepts the request currently on the inputs, so its beats are queued now.
    task automatic waitAccept(string tag);
        int waited;
        waited = 0;
        while (camBus.upd_ready !== 1'b1 && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (camBus.upd_ready === 1'b1)
            pushRequest(camBus.upd_op, camBus.upd_entry, camBus.upd_key, reqMask, tag);
        else
            checkValue({tag, "_accept_timeout"}, 128'(camBus.upd_ready), 128'd1);
    endtask

    task automatic scramble(logic validVal);
        camBus.upd_valid = validVal;
        camBus.upd_op    = 1'($urandom);
        camBus.upd_entry = ENTRY_W'($urandom_range(0, 63));
        camBus.upd_key   = KEY_W'($urandom);
        reqMask          = KEY_W'($urandom);
    endtask

    task automatic clearHits();
        for (int s = 0; s < SLICES; s++) hitMap[s] = '0;
    endtask

    initial begin
        exp_t idle;
        idle.v = mkBeat('0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);

        rst_n            = 1'b1;
        camBus.upd_valid = 1'b0;
        camBus.upd_op    = 1'b0;
        camBus.upd_entry = '0;
        camBus.upd_key   = '0;
        clearHits();

        // T1: asynchronous reset mid-cycle
        #12;
        rst_n = 1'b0;
        #1;
        checkValue("reset_async", 128'(observe()), 128'(idle.v));
        @(negedge clk);
        rst_n = 1'b1;
        idle.tag = "reset_idle";
        expQ.push_back(idle);
        checkOutput(1);

        // T2: write entry 3, slices {63,0,17,42}; garbage with valid high during the sweep
        applyStimulus(1'b1, 6'd3, {6'd63, 6'd0, 6'd17, 6'd42}, '0);
        waitAccept("wr3");
        clearHits();
        checkOutput(1);
        scramble(1'b1);
        checkOutput(63);
        camBus.upd_valid = 1'b0;
        checkOutput(2);
        checkValue("wr3_slice0_map", 128'(hitMap[0]), 128'(64'd1 << 42));
        checkValue("wr3_slice1_map", 128'(hitMap[1]), 128'(64'd1 << 17));
        checkValue("wr3_slice2_map", 128'(hitMap[2]), 128'(64'd1));
        checkValue("wr3_slice3_map", 128'(hitMap[3]), 128'(64'd1 << 63));

        // T3: delete entry 31 (key present but must not be written)
        applyStimulus(1'b0, 6'd31, 24'hA5C3F0, '0);
        waitAccept("del31");
        clearHits();
        checkOutput(1);
        camBus.upd_valid = 1'b0;
        checkOutput(65);
        checkValue("del31_no_ones", 128'(hitMap[0] | hitMap[1] | hitMap[2] | hitMap[3]), 128'd0);

        // T4: back-to-back writes with upd_valid held high
        applyStimulus(1'b1, 6'd7, {6'd1, 6'd2, 6'd3, 6'd4}, '0);
        waitAccept("b2bA");
        checkOutput(1);
        applyStimulus(1'b1, 6'd12, {6'd60, 6'd50, 6'd40, 6'd30}, '0);
        checkOutput(65);
        waitAccept("b2bB");
        checkOutput(1);
        camBus.upd_valid = 1'b0;
        checkOutput(65);

        // T6: out-of-range entries (first index past the end, and 40)
        applyStimulus(1'b1, 6'd32, 24'h123456, '0);
        waitAccept("oor32");
        checkOutput(1);
        camBus.upd_valid = 1'b0;
        checkOutput(1);
        applyStimulus(1'b1, 6'd40, 24'h654321, '0);
        waitAccept("oor40");
        checkOutput(1);
        camBus.upd_valid = 1'b0;
        checkOutput(1);

        // T5: reset while wr_addr == 20
        applyStimulus(1'b1, 6'd5, {6'd9, 6'd8, 6'd7, 6'd6}, '0);
        waitAccept("rst_mid");
        checkOutput(1);
        camBus.upd_valid = 1'b0;
        checkOutput(20);
        #2;
        rst_n = 1'b0;
        #1;
        checkValue("rst_mid_async", 128'(observe()), 128'(idle.v));
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle.tag = "rst_mid_after";
        repeat (3) expQ.push_back(idle);
        checkOutput(3);

`ifdef CAM_UPD_TERNARY_EN
        // Ternary: slice0 key 8 with low two bits masked -> addresses 8..11
        applyStimulus(1'b1, 6'd2, {6'd5, 6'd5, 6'd5, 6'd8}, {6'd0, 6'd0, 6'd0, 6'b000011});
        waitAccept("tern");
        clearHits();
        checkOutput(1);
        camBus.upd_valid = 1'b0;
        checkOutput(65);
        checkValue("tern_slice0_map", 128'(hitMap[0]), 128'(64'h0000_0000_0000_0F00));
        checkValue("tern_slice1_map", 128'(hitMap[1]), 128'(64'd1 << 5));
`endif

        checkValue("queue_drained", 128'(expQ.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
